// File: rtl/crc16_tx_seq.sv
// Reply bit sequencer: streams the payload to the modulator while feeding an external CRC16 engine,
// then streams the engine's 16 CRC bits MSB first. Define CRC16_SEQ_DUMMY1_EN to append the trailing dummy-1.
module crc16_tx_seq #(
  parameter int unsigned MAXBITS = 128,
  parameter int unsigned LENW    = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            abort,
  input  logic [LENW-1:0] payload_len,
  input  logic            use_crc,
  input  logic            data_bit,
  output logic            data_adv,
  input  logic            tx_ready,
  output logic            tx_valid,
  output logic            tx_bit,
  output logic            tx_last,
  output logic            crc_clr,
  output logic            crc_in_en,
  output logic            crc_bit_in,
  output logic            crc_out_en,
  input  logic            crc_bit,
  output logic            busy,
  output logic            done
);

  localparam int unsigned     CNTW     = 4;
  localparam logic [LENW-1:0] MAX_LEN  = LENW'(MAXBITS);
  localparam logic [LENW-1:0] LEN_ONE  = LENW'(1);
  localparam logic [CNTW-1:0] CRC_LAST = CNTW'(15);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DATA,
    ST_CRC,
    ST_DUMMY,
    ST_FINISH
  } state_t;

  // Tail of the reply: either the dummy-1 bit or straight to completion.
`ifdef CRC16_SEQ_DUMMY1_EN
  localparam state_t ST_TAIL     = ST_DUMMY;
  localparam logic   LAST_ON_BIT = 1'b0;
`else
  localparam state_t ST_TAIL     = ST_FINISH;
  localparam logic   LAST_ON_BIT = 1'b1;
`endif

  state_t          state_q, state_d;
  logic [LENW-1:0] len_q, len_d;
  logic            use_crc_q, use_crc_d;
  logic [CNTW-1:0] crccnt_q, crccnt_d;
  logic [LENW-1:0] len_clamped;

  assign len_clamped = (payload_len > MAX_LEN) ? MAX_LEN : payload_len;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      use_crc_q <= 1'b0;
      crccnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      use_crc_q <= use_crc_d;
      crccnt_q  <= crccnt_d;
    end
  end

  // Next state and outputs; engine strobes fire in the transfer cycle itself.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    use_crc_d  = use_crc_q;
    crccnt_d   = crccnt_q;
    data_adv   = 1'b0;
    tx_valid   = 1'b0;
    tx_bit     = 1'b0;
    tx_last    = 1'b0;
    crc_clr    = 1'b0;
    crc_in_en  = 1'b0;
    crc_bit_in = 1'b0;
    crc_out_en = 1'b0;
    done       = 1'b0;
    busy       = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d     = len_clamped;
          use_crc_d = use_crc;
          crccnt_d  = '0;
          state_d   = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        crc_clr = 1'b1;
        if (len_q != '0)    state_d = ST_DATA;
        else if (use_crc_q) state_d = ST_CRC;
        else                state_d = ST_TAIL;
      end

      ST_DATA: begin
        tx_valid = 1'b1;
        tx_bit   = data_bit;
        tx_last  = LAST_ON_BIT && !use_crc_q && (len_q == LEN_ONE);
        if (tx_ready) begin
          data_adv   = 1'b1;
          crc_in_en  = use_crc_q;
          crc_bit_in = use_crc_q && data_bit;
          len_d      = len_q - LEN_ONE;
          if (len_q == LEN_ONE) state_d = use_crc_q ? ST_CRC : ST_TAIL;
        end
      end

      ST_CRC: begin
        tx_valid = 1'b1;
        tx_bit   = crc_bit;
        tx_last  = LAST_ON_BIT && (crccnt_q == CRC_LAST);
        if (tx_ready) begin
          crc_out_en = 1'b1;
          if (crccnt_q == CRC_LAST) state_d  = ST_TAIL;
          else                      crccnt_d = crccnt_q + CNTW'(1);
        end
      end

      ST_DUMMY: begin
        tx_valid = 1'b1;
        tx_bit   = 1'b1;
        tx_last  = 1'b1;
        if (tx_ready) state_d = ST_FINISH;
      end

      ST_FINISH: begin
        done    = !abort;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

endmodule

// File: tb/tb_crc16_tx_seq.sv
// Bench for crc16_tx_seq: payload source and CRC16 engine models, expected bits queued per reply.
module tb_crc16_tx_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, abort, use_crc, tx_ready;
  logic [7:0] payload_len;
  logic       data_bit, crc_bit;
  logic       data_adv, tx_valid, tx_bit, tx_last, crc_clr, crc_in_en, crc_bit_in, crc_out_en, busy, done;

  always #5 clk = ~clk;

  crc16_tx_seq #(.MAXBITS(128), .LENW(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .payload_len(payload_len),
    .use_crc(use_crc), .data_bit(data_bit), .data_adv(data_adv), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_bit(tx_bit), .tx_last(tx_last), .crc_clr(crc_clr),
    .crc_in_en(crc_in_en), .crc_bit_in(crc_bit_in), .crc_out_en(crc_out_en),
    .crc_bit(crc_bit), .busy(busy), .done(done)
  );

`ifdef CRC16_SEQ_DUMMY1_EN
  localparam int DX = 1;
`else
  localparam int DX = 0;
`endif

  int checks = 0;
  int errors = 0;

  // Payload source: MSB first, advances on data_adv, rewinds on an accepted start.
  logic [127:0] src_payload = '0;
  int           src_len = 0;
  int           src_idx;
  always_comb data_bit = (src_idx < src_len) ? src_payload[7'(src_len - 1 - src_idx)] : 1'b0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)             src_idx <= 0;
    else if (start && !busy)  src_idx <= 0;
    else if (data_adv)        src_idx <= src_idx + 1;
  end

  // CRC16 engine (Gen2: preset, poly 0x1021, inverted readout MSB first).
  logic [15:0] preset = 16'hFFFF;
  logic [15:0] eng;
  always_comb crc_bit = ~eng[15];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)        eng <= 16'hFFFF;
    else if (crc_clr)    eng <= preset;
    else if (crc_in_en)  eng <= {eng[14:0], 1'b0} ^ ((eng[15] ^ crc_bit_in) ? 16'h1021 : 16'h0000);
    else if (crc_out_en) eng <= {eng[14:0], 1'b0};
  end

  function automatic logic [15:0] crc16_ref(input logic [127:0] pl, input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[15] ^ pl[7'(i)];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return ~c;
  endfunction

  typedef struct packed { logic b; logic last; } sb_t;
  sb_t exp_q[$];

  typedef struct {
    int unsigned  len;
    logic         crc;
    logic [127:0] pl;
    int           mode;
    logic         pat;
    int           exp_x, exp_in, exp_out, exp_adv;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One reply: queue expected bits, start, run cycle by cycle checking every transfer.
  task automatic run_reply(input int unsigned len, input logic crc, input logic [127:0] pl,
                           input int mode, input logic pat, input int restart_at, input int abort_after,
                           output int n_x, output int n_in, output int n_out, output int n_adv,
                           output int n_clr, output int n_done);
    int eff, cyc, total, last_x_cyc;
    logic [15:0] cv;
    logic prev_stall, prev_bit, fin, aborted, restarted, xfer;
    sb_t e;
    eff = (len > 128) ? 128 : int'(len);
    exp_q.delete();
    for (int i = 0; i < eff; i++) exp_q.push_back('{b: pl[7'(eff - 1 - i)], last: 1'b0});
    if (crc) begin
      cv = pat ? 16'hA5A5 : crc16_ref(pl, eff);
      for (int k = 15; k >= 0; k--) exp_q.push_back('{b: cv[4'(k)], last: 1'b0});
    end
    if (DX == 1) exp_q.push_back('{b: 1'b1, last: 1'b0});
    total = exp_q.size();
    if (total > 0) exp_q[total - 1].last = 1'b1;
    src_payload = pl; src_len = eff; preset = pat ? 16'h5A5A : 16'hFFFF;
    payload_len = 8'(len); use_crc = crc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_x = 0; n_in = 0; n_out = 0; n_adv = 0; n_clr = 0; n_done = 0;
    cyc = 0; last_x_cyc = -10; prev_stall = 0; prev_bit = 0; fin = 0; aborted = 0; restarted = 0;
    while (!fin && cyc < 2000) begin
      tx_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 2);
      abort = 1'b0; start = 1'b0;
      if (abort_after > 0 && n_x == abort_after) begin abort = 1'b1; tx_ready = 1'b0; end
      if (restart_at > 0 && n_x == restart_at && !restarted) begin
        start = 1'b1; payload_len = 8'd8; restarted = 1'b1;
      end
      @(negedge clk);
      xfer = tx_valid && tx_ready;
      chk("strobe_excl", 32'((crc_in_en & crc_out_en) | (crc_clr & (crc_in_en | crc_out_en))), 0);
      chk("adv_gated", 32'((data_adv | crc_out_en) & ~xfer), 0);
      if (cyc == 0) begin
        chk("clear_cycle_clr", 32'(crc_clr), 1);
        chk("clear_cycle_valid", 32'(tx_valid), 0);
      end
      if (cyc == 1 && total > 0) chk("first_valid_latency", 32'(tx_valid), 1);
      if (prev_stall) begin
        chk("stall_valid_held", 32'(tx_valid), 1);
        chk("stall_bit_held", 32'(tx_bit), 32'(prev_bit));
      end
      n_in += int'(crc_in_en); n_out += int'(crc_out_en); n_adv += int'(data_adv); n_clr += int'(crc_clr);
      if (xfer) begin
        chk("xfer_pending", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk($sformatf("tx_bit[%0d]", n_x), 32'(tx_bit), 32'(e.b));
          chk($sformatf("tx_last[%0d]", n_x), 32'(tx_last), 32'(e.last));
        end
        n_x++; last_x_cyc = cyc;
      end else if (!tx_valid) begin
        chk("last_without_valid", 32'(tx_last), 0);
      end
      if (done) begin
        n_done++;
        chk("done_timing", cyc, (total == 0) ? 1 : last_x_cyc + 1);
        fin = 1'b1;
      end
      if (abort) begin aborted = 1'b1; fin = 1'b1; end
      prev_stall = tx_valid && !tx_ready;
      prev_bit = tx_bit;
      @(posedge clk); #1;
      cyc++;
    end
    chk("reply_ended", 32'(fin), 1);
    abort = 1'b0; start = 1'b0; tx_ready = 1'b1;
    @(negedge clk);
    chk("after_valid", 32'(tx_valid), 0);
    chk("after_busy", 32'(busy), 0);
    chk("after_done", 32'(done), 0);
    if (aborted) begin
      repeat (3) begin
        @(negedge clk);
        chk("abort_no_done", 32'(done), 0);
        n_done += int'(done);
      end
    end
    @(posedge clk); #1;
  endtask

  vec_t       vt[6];
  logic [9:0] outs;
  string      onames[10] = '{"data_adv", "tx_valid", "tx_bit", "tx_last", "crc_clr",
                             "crc_in_en", "crc_bit_in", "crc_out_en", "busy", "done"};
  int nx, nin, nout, nadv, nclr, ndone;
  logic [127:0] rnd;

  initial begin
    vt[0] = '{16, 1'b1, 128'hBEEF, 0, 1'b0, 32 + DX, 16, 16, 16};
    vt[1] = '{0,  1'b1, 128'h0,    0, 1'b1, 16 + DX, 0,  16, 0};
    vt[2] = '{8,  1'b0, 128'h5A,   1, 1'b0, 8 + DX,  0,  0,  8};
    vt[3] = '{0,  1'b0, 128'h0,    0, 1'b0, 0 + DX,  0,  0,  0};
    vt[4] = '{1,  1'b1, 128'h1,    1, 1'b0, 17 + DX, 1,  16, 1};
    vt[5] = '{12, 1'b1, 128'h9C3,  1, 1'b0, 28 + DX, 12, 16, 12};

    reset_n = 1'b0; start = 1'b0; abort = 1'b0; use_crc = 1'b0; payload_len = '0; tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    outs = {done, busy, crc_out_en, crc_bit_in, crc_in_en, crc_clr, tx_last, tx_bit, tx_valid, data_adv};
    for (int i = 0; i < 10; i++) chk({"reset_", onames[i]}, 32'(outs[4'(i)]), 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      run_reply(vt[v].len, vt[v].crc, vt[v].pl, vt[v].mode, vt[v].pat, 0, 0,
                nx, nin, nout, nadv, nclr, ndone);
      chk($sformatf("v%0d_xfers", v), nx, vt[v].exp_x);
      chk($sformatf("v%0d_in_en", v), nin, vt[v].exp_in);
      chk($sformatf("v%0d_out_en", v), nout, vt[v].exp_out);
      chk($sformatf("v%0d_adv", v), nadv, vt[v].exp_adv);
      chk($sformatf("v%0d_clr", v), nclr, 1);
      chk($sformatf("v%0d_done", v), ndone, 1);
    end

    // Abort after transfer 5, then a fresh full reply.
    run_reply(16, 1'b1, 128'hBEEF, 0, 1'b0, 0, 5, nx, nin, nout, nadv, nclr, ndone);
    chk("abort_xfers", nx, 5);
    chk("abort_in_en", nin, 5);
    chk("abort_adv", nadv, 5);
    chk("abort_done", ndone, 0);
    run_reply(16, 1'b1, 128'hBEEF, 0, 1'b0, 0, 0, nx, nin, nout, nadv, nclr, ndone);
    chk("post_abort_xfers", nx, 32 + DX);
    chk("post_abort_done", ndone, 1);

    // Over-long payload clamped to MAXBITS, with a second start mid-reply.
    rnd = {$urandom, $urandom, $urandom, $urandom};
    run_reply(200, 1'b1, rnd, 0, 1'b0, 10, 0, nx, nin, nout, nadv, nclr, ndone);
    chk("clamp_xfers", nx, 144 + DX);
    chk("clamp_adv", nadv, 128);
    chk("clamp_in_en", nin, 128);
    chk("clamp_clr", nclr, 1);
    chk("clamp_done", ndone, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
